// File: rtl/score_timer_pkg.sv
// Purpose : shared types and constants for the whack-a-mole score/time display block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package score_timer_pkg;

  // Game state encoding as seen on the state output pins.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  // Value shown on an unlit seven-segment digit.
  localparam logic [3:0] BLANK   = 4'hF;

  // BCD digit limits.
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Two-digit BCD image of a small integer (0..99): {tens, ones}.
  function automatic logic [7:0] to_bcd2(input int value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/score_timer_bcd_digit.sv
// Purpose : one registered BCD digit with increment/decrement enables and terminal flags.
// Latency : q updates on the edge that samples inc/dec/load; carry/borrow follow q combinationally.
// Backpressure: none; the digit accepts an enable every cycle.
//
// Ports:
//   nclk, rst_n : clock, asynchronous active-low reset (q returns to INIT)
//   load        : synchronous reload of INIT, overrides inc/dec
//   inc, dec    : count up / down by one with 9<->0 wrap; both together is a no-op
//   q           : current digit value
//   carry       : digit sits at 9, so an inc here ripples into the next digit
//   borrow      : digit sits at 0, so a dec here ripples into the next digit
module bcd_digit
  import score_timer_pkg::*;
#(
  parameter logic [3:0] INIT = BCD_MIN
) (
  input  logic       nclk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] q,
  output logic       carry,
  output logic       borrow
);

  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (load) begin
      q <= INIT;
    end else if (inc && !dec) begin
      q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
    end else if (dec && !inc) begin
      q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  // Terminal flags are level indications of the stored value, independent of
  // the enables, so a chain can gate its upper digits with an AND of them.
  assign carry  = (q == BCD_MAX);
  assign borrow = (q == BCD_MIN);

endmodule

// File: rtl/score_timer.sv
// Purpose : whack-a-mole round controller: countdown timer, saturating BCD score, 8-digit display feed.
// Latency : every output is a register; score/time/state move on the edge that samples start/hit/miss/tick.
// Backpressure: none; start/hit/miss are single-cycle pulses and are never stalled.
//
// Ports:
//   nclk, rst_n     : scan clock, asynchronous active-low reset
//   start           : begins a round from IDLE or OVER (ignored while running)
//   hit, miss       : +1 / -1 to the score while running (both together cancel)
//   state           : 00 IDLE, 01 RUN, 10 OVER
//   game_over       : high exactly while state is OVER
//   disp7, disp6    : remaining seconds, BCD tens / ones
//   disp5, disp4    : permanently blank digits
//   disp3 .. disp0  : score, BCD thousands .. ones
module score_timer
  import score_timer_pkg::*;
#(
  parameter int GAME_SECONDS = 60,
  parameter int TICK_DIV     = 1000
) (
  input  logic       nclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [1:0] state,
  output logic       game_over,
  output logic [3:0] disp7,
  output logic [3:0] disp6,
  output logic [3:0] disp5,
  output logic [3:0] disp4,
  output logic [3:0] disp3,
  output logic [3:0] disp2,
  output logic [3:0] disp1,
  output logic [3:0] disp0
);

  localparam logic [7:0] TIME_INIT = to_bcd2(GAME_SECONDS);
  localparam int         PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  state_t          st;
  logic [PW-1:0]   ps;
  logic            run;
  logic            do_start;
  logic            tick;
  logic            time_last;

  assign run      = (st == ST_RUN);
  assign do_start = start && !run;
  assign tick     = run && (ps == PS_LAST);

  // ---------------------------------------------------------------------------
  // Score: four-digit BCD chain with saturation at both ends
  // ---------------------------------------------------------------------------
  logic [3:0] s_q [4];
  logic [3:0] s_carry;
  logic [3:0] s_borrow;
  logic [3:0] s_inc;
  logic [3:0] s_dec;
  logic       score_max;
  logic       score_zero;
  logic       sc_inc;
  logic       sc_dec;

  assign score_max  = &s_carry;
  assign score_zero = &s_borrow;

  // A simultaneous hit and miss cancels; the rails are enforced here rather
  // than in the digits so the chain itself stays a plain wrapping counter.
  assign sc_inc = run && hit && !miss && !score_max;
  assign sc_dec = run && miss && !hit && !score_zero;

  // Digit i moves only when every lower digit is about to wrap.
  assign s_inc = {sc_inc & (&s_carry[2:0]),
                  sc_inc & (&s_carry[1:0]),
                  sc_inc & s_carry[0],
                  sc_inc};
  assign s_dec = {sc_dec & (&s_borrow[2:0]),
                  sc_dec & (&s_borrow[1:0]),
                  sc_dec & s_borrow[0],
                  sc_dec};

  for (genvar i = 0; i < 4; i++) begin : g_score
    bcd_digit #(
      .INIT (BCD_MIN)
    ) u_digit (
      .nclk   (nclk),
      .rst_n  (rst_n),
      .load   (do_start),
      .inc    (s_inc[i]),
      .dec    (s_dec[i]),
      .q      (s_q[i]),
      .carry  (s_carry[i]),
      .borrow (s_borrow[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Time: two-digit BCD down-counter, decremented once per prescaler wrap
  // ---------------------------------------------------------------------------
  logic [3:0] t_q [2];
  logic [1:0] t_carry;
  logic [1:0] t_borrow;
  logic [1:0] t_dec;

  assign t_dec = {tick & t_borrow[0], tick};

  bcd_digit #(
    .INIT (TIME_INIT[3:0])
  ) u_time_ones (
    .nclk   (nclk),
    .rst_n  (rst_n),
    .load   (do_start),
    .inc    (1'b0),
    .dec    (t_dec[0]),
    .q      (t_q[0]),
    .carry  (t_carry[0]),
    .borrow (t_borrow[0])
  );

  bcd_digit #(
    .INIT (TIME_INIT[7:4])
  ) u_time_tens (
    .nclk   (nclk),
    .rst_n  (rst_n),
    .load   (do_start),
    .inc    (1'b0),
    .dec    (t_dec[1]),
    .q      (t_q[1]),
    .carry  (t_carry[1]),
    .borrow (t_borrow[1])
  );

  // The time never counts up, so its carry flags have no consumer.
  logic unused_time_carry;
  assign unused_time_carry = ^t_carry;

  // Time reads 01: the next tick lands on 00 and ends the round.
  assign time_last = t_borrow[1] && (t_q[0] == 4'd1);

  // ---------------------------------------------------------------------------
  // FSM, prescaler and game_over flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge nclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_IDLE;
      ps        <= '0;
      game_over <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          ps <= '0;
          if (start) begin
            st <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            ps <= '0;
            if (time_last) begin
              st        <= ST_OVER;
              game_over <= 1'b1;
            end
          end else begin
            ps <= ps + PW'(1);
          end
        end
        ST_OVER: begin
          ps <= '0;
          if (start) begin
            st        <= ST_RUN;
            game_over <= 1'b0;
          end
        end
        default: begin
          st        <= ST_IDLE;
          ps        <= '0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all sourced straight from registers)
  // ---------------------------------------------------------------------------
  assign state = st;
  assign disp7 = t_q[1];
  assign disp6 = t_q[0];
  assign disp5 = BLANK;
  assign disp4 = BLANK;
  assign disp3 = s_q[3];
  assign disp2 = s_q[2];
  assign disp1 = s_q[1];
  assign disp0 = s_q[0];

endmodule

// File: tb/tb_score_timer.sv
module tb_score_timer;

  localparam int GS = 10;
  localparam int TD = 4;

  logic       nclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hit   = 1'b0;
  logic       miss  = 1'b0;
  logic [1:0] state;
  logic       game_over;
  logic [3:0] disp7, disp6, disp5, disp4, disp3, disp2, disp1, disp0;

  // Second instance for the long saturation run.
  logic       s_start = 1'b0;
  logic       s_hit   = 1'b0;
  logic       s_miss  = 1'b0;
  logic [1:0] s_state;
  logic       s_go;
  logic [3:0] s_d7, s_d6, s_d5, s_d4, s_d3, s_d2, s_d1, s_d0;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: {state, game_over, disp7, disp6, disp3..disp0}
  logic [26:0] exp_q[$];
  logic [26:0] got;
  logic [26:0] want;

  // Reference model state
  int m_state;
  int m_time;
  int m_score;
  int m_ps;

  always #5 nclk = ~nclk;

  score_timer #(.GAME_SECONDS(GS), .TICK_DIV(TD)) dut (
    .nclk(nclk), .rst_n(rst_n), .start(start), .hit(hit), .miss(miss),
    .state(state), .game_over(game_over),
    .disp7(disp7), .disp6(disp6), .disp5(disp5), .disp4(disp4),
    .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
  );

  score_timer #(.GAME_SECONDS(99), .TICK_DIV(20000)) dut_sat (
    .nclk(nclk), .rst_n(rst_n), .start(s_start), .hit(s_hit), .miss(s_miss),
    .state(s_state), .game_over(s_go),
    .disp7(s_d7), .disp6(s_d6), .disp5(s_d5), .disp4(s_d4),
    .disp3(s_d3), .disp2(s_d2), .disp1(s_d1), .disp0(s_d0)
  );

  function automatic logic [15:0] bcd4(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [26:0] model_vec();
    return {2'(m_state), (m_state == 2), 4'(m_time / 10), 4'(m_time % 10), bcd4(m_score)};
  endfunction

  function automatic logic [26:0] obs();
    return {state, game_over, disp7, disp6, disp3, disp2, disp1, disp0};
  endfunction

  task automatic model_reset();
    m_state = 0; m_time = GS; m_score = 0; m_ps = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic s, input logic h, input logic m);
    case (m_state)
      1: begin
        if (h && !m && m_score < 9999) m_score++;
        else if (m && !h && m_score > 0) m_score--;
        if (m_ps == TD - 1) begin
          m_ps = 0;
          m_time--;
          if (m_time == 0) m_state = 2;
        end else begin
          m_ps++;
        end
      end
      default: if (s) begin
        m_state = 1; m_time = GS; m_score = 0; m_ps = 0;
      end
    endcase
  endtask

  // Drive one cycle of inputs, advance the model on the edge, queue the expectation.
  task automatic cyc(input logic s, input logic h, input logic m);
    start = s; hit = h; miss = m;
    @(posedge nclk);
    model_step(s, h, m);
    exp_q.push_back(model_vec());
    #1;
    start = 1'b0; hit = 1'b0; miss = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge nclk); #3;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (obs() !== {2'b00, 1'b0, 4'd1, 4'd0, 16'h0000}) begin
      n_fail++; $display("FAIL reset_vals got=%h want=%h", obs(), {2'b00, 1'b0, 4'd1, 4'd0, 16'h0000});
    end
    n_checks++;
    if ({disp5, disp4} !== 8'hFF) begin
      n_fail++; $display("FAIL reset_blank got=%h want=ff", {disp5, disp4});
    end
    #1 rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL reset_idle_cycle got=%h want=%h", got, want); end
  endtask

  task automatic test_countdown();
    cyc(1, 0, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL cd_start got=%h want=%h", got, want); end
    n_checks++;
    if ({state, disp7, disp6} !== {2'b01, 8'h10}) begin
      n_fail++; $display("FAIL cd_start_const got=%h want=110", {state, disp7, disp6});
    end
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 0);
      want = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL cd_cycle%0d got=%h want=%h", i, got, want); end
      if (i == 4 || i == 8) begin
        n_checks++;
        if ({disp7, disp6} !== ((i == 4) ? 8'h09 : 8'h08)) begin
          n_fail++; $display("FAIL cd_time_at%0d got=%h", i, {disp7, disp6});
        end
      end
      if (i == 39 || i == 40) begin
        n_checks++;
        if ({state, game_over, disp7, disp6} !== ((i == 40) ? {2'b10, 1'b1, 8'h00} : {2'b01, 1'b0, 8'h01})) begin
          n_fail++; $display("FAIL cd_end_at%0d got=%h", i, {state, game_over, disp7, disp6});
        end
      end
    end
  endtask

  task automatic test_scoring();
    // start from OVER restarts the round
    cyc(1, 0, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got !== {2'b01, 1'b0, 8'h10, 16'h0000}) begin
      n_fail++; $display("FAIL sc_restart got=%h want=%h", got, want);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0);
      want = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL sc_hit%0d got=%h want=%h", i, got, want); end
    end
    n_checks++;
    if ({disp3, disp2, disp1, disp0} !== 16'h0012) begin
      n_fail++; $display("FAIL sc_12hits got=%h want=0012", {disp3, disp2, disp1, disp0});
    end
    cyc(0, 0, 1);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got[15:0] !== 16'h0011) begin
      n_fail++; $display("FAIL sc_miss got=%h want=%h", got, want);
    end
    cyc(0, 1, 1);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got[15:0] !== 16'h0011) begin
      n_fail++; $display("FAIL sc_hit_and_miss got=%h want=%h", got, want);
    end
    // start while running must not reload anything
    cyc(1, 0, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL sc_start_in_run got=%h want=%h", got, want); end
    for (int k = 0; k < 100 && m_state == 1; k++) begin
      cyc(0, 0, 0);
      want = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL sc_runout%0d got=%h want=%h", k, got, want); end
    end
    n_checks++;
    if (m_state != 2) begin n_fail++; $display("FAIL sc_runout_timeout got=%0d want=2", m_state); end
    // hit while OVER is ignored
    cyc(0, 1, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got !== {2'b10, 1'b1, 8'h00, 16'h0011}) begin
      n_fail++; $display("FAIL sc_hit_in_over got=%h want=%h", got, want);
    end
  endtask

  task automatic test_sat_low();
    cyc(1, 0, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL low_start got=%h want=%h", got, want); end
    cyc(0, 0, 1);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got[15:0] !== 16'h0000) begin
      n_fail++; $display("FAIL low_miss_at_zero got=%h want=%h", got, want);
    end
    cyc(0, 1, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got[15:0] !== 16'h0001) begin
      n_fail++; $display("FAIL low_hit_after got=%h want=%h", got, want);
    end
  endtask

  task automatic test_reset_mid_run();
    cyc(0, 1, 0);
    void'(exp_q.pop_front());
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== {2'b00, 1'b0, 8'h10, 16'h0000} || {disp5, disp4} !== 8'hFF) begin
      n_fail++; $display("FAIL midrun_reset got=%h want=%h", obs(), {2'b00, 1'b0, 8'h10, 16'h0000});
    end
    #1 rst_n = 1'b1;
    model_reset();
    // hit in IDLE is ignored
    cyc(0, 1, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got !== {2'b00, 1'b0, 8'h10, 16'h0000}) begin
      n_fail++; $display("FAIL idle_hit got=%h want=%h", got, want);
    end
    cyc(1, 0, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL restart got=%h want=%h", got, want); end
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 0);
      want = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL restart_cyc%0d got=%h want=%h", i, got, want); end
    end
    n_checks++;
    if ({disp7, disp6} !== 8'h09) begin
      n_fail++; $display("FAIL restart_time got=%h want=09", {disp7, disp6});
    end
  endtask

  task automatic test_final_tick();
    for (int k = 0; k < 100 && !(m_time == 1 && m_ps == TD - 1); k++) begin
      cyc(0, 0, 0);
      want = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL ft_run%0d got=%h want=%h", k, got, want); end
    end
    cyc(0, 1, 0);
    want = exp_q.pop_front(); got = obs(); n_checks++;
    if (got !== want || got !== {2'b10, 1'b1, 8'h00, 16'h0001}) begin
      n_fail++; $display("FAIL final_tick_hit got=%h want=%h", got, want);
    end
  endtask

  task automatic test_saturation();
    @(posedge nclk); #1 s_start = 1'b1;
    @(posedge nclk); #1 s_start = 1'b0;
    n_checks++;
    if ({s_state, s_go, s_d7, s_d6, s_d5, s_d4, s_d3, s_d2, s_d1, s_d0} !== {2'b01, 1'b0, 32'h99FF0000}) begin
      n_fail++; $display("FAIL sat_start got=%h", {s_state, s_go, s_d7, s_d6, s_d5, s_d4, s_d3, s_d2, s_d1, s_d0});
    end
    s_hit = 1'b1;
    repeat (1234) @(posedge nclk);
    #1;
    n_checks++;
    if ({s_d3, s_d2, s_d1, s_d0} !== 16'h1234) begin
      n_fail++; $display("FAIL sat_1234 got=%h want=1234", {s_d3, s_d2, s_d1, s_d0});
    end
    repeat (9999 - 1234) @(posedge nclk);
    #1;
    n_checks++;
    if ({s_d3, s_d2, s_d1, s_d0} !== 16'h9999) begin
      n_fail++; $display("FAIL sat_9999 got=%h want=9999", {s_d3, s_d2, s_d1, s_d0});
    end
    repeat (2) @(posedge nclk);
    #1;
    n_checks++;
    if ({s_state, s_d3, s_d2, s_d1, s_d0} !== {2'b01, 16'h9999}) begin
      n_fail++; $display("FAIL sat_hold got=%h want=19999", {s_state, s_d3, s_d2, s_d1, s_d0});
    end
    s_hit = 1'b0; s_miss = 1'b1;
    @(posedge nclk); #1 s_miss = 1'b0;
    n_checks++;
    if ({s_d3, s_d2, s_d1, s_d0} !== 16'h9998) begin
      n_fail++; $display("FAIL sat_miss_from_max got=%h want=9998", {s_d3, s_d2, s_d1, s_d0});
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_countdown();
    test_scoring();
    test_sat_low();
    test_reset_mid_run();
    test_final_tick();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_timer.md
SCORE_TIMER -- requirements
Module: score_timer

Interface
REQ-001 Parameter GAME_SECONDS, default 60: round length in seconds; legal range 1..99.
REQ-002 Parameter TICK_DIV, default 1000: nclk cycles per game second; legal minimum 2.
REQ-003 nclk  input  1  clock, rising-edge active; the divided scan clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse, synchronous to nclk; begins a round.
REQ-006 hit  input  1  one-cycle pulse, synchronous to nclk; mole struck, score +1.
REQ-007 miss  input  1  one-cycle pulse, synchronous to nclk; empty hole struck, score -1.
REQ-008 state  output  2  game state: 00 IDLE, 01 RUN, 10 OVER.
REQ-009 game_over  output  1  high exactly while state is OVER.
REQ-010 disp7..disp6  output  4 each  remaining time as BCD, tens then ones.
REQ-011 disp5..disp4  output  4 each  constant 4'hF (BLANK; digit unlit).
REQ-012 disp3..disp0  output  4 each  score as BCD, thousands down to ones.

Function
REQ-013 All outputs shall be registered and change only on a rising nclk edge or on reset.
REQ-014 FSM transitions: IDLE --start--> RUN; RUN --time reaches 00--> OVER; OVER --start--> RUN; no other transitions.
REQ-015 On entry to RUN: score = 0000, time = GAME_SECONDS in BCD, prescaler = 0; all effective on the edge that samples start.
REQ-016 In RUN, the prescaler shall count 0..TICK_DIV-1 and wrap; a tick is the cycle in which it equals TICK_DIV-1.
REQ-017 On each tick, time shall decrement by one in BCD; ones 0 wraps to 9 with a borrow from tens (e.g., 10 -> 09).
REQ-018 The tick that takes time from 01 to 00 shall move state to OVER on the same edge.
REQ-019 Score shall change only in RUN, one cycle after the sampled pulse: hit alone +1, miss alone -1, hit and miss together: no change.
REQ-020 Score saturates: +1 at 9999 stays 9999; -1 at 0000 stays 0000.
REQ-021 A hit or miss sampled on the final tick edge shall be counted.
REQ-022 start shall be ignored in RUN; hit and miss shall be ignored in IDLE and OVER.
REQ-023 In OVER, time shall read 00 and score shall hold its final value until the next start.
REQ-024 In IDLE, time shall read GAME_SECONDS and score shall read 0000.

Reset
REQ-025 While rst_n = 0: state = IDLE; game_over = 0; time = GAME_SECONDS; score = 0000; prescaler = 0; disp5 and disp4 = 4'hF.
REQ-026 Reset shall take effect asynchronously, including in the middle of RUN, and shall discard any pending tick.
REQ-027 After rst_n deasserts, the first active edge shall behave as an ordinary IDLE cycle.

Structure
REQ-028 Package score_timer_pkg shall hold: the state encoding (IDLE/RUN/OVER), BLANK = 4'hF, and BCD limit constants (9, 0).
REQ-029 One sub-module, bcd_digit, shall implement a 4-bit BCD digit with inc/dec enable and carry/borrow out.
REQ-030 The score shall be a chain of four bcd_digit instances, and the time a chain of two; saturation logic shall sit in score_timer.

Verification (bench: TICK_DIV=4, GAME_SECONDS=10 unless stated otherwise)
REQ-031 Reset: pulse rst_n low mid-cycle -> immediately state=00, disp7..6=1,0, disp3..0=0000, disp5..4=F,F.
REQ-032 Countdown: start, no hits -> time 10, 09 at cycle 4, 08 at cycle 8; 00 at cycle 40 with state=10 and game_over=1 on that same edge.
REQ-033 Scoring: 12 hits in RUN -> 0012; then 1 miss -> 0011; then hit+miss in one cycle -> 0011.
REQ-034 Saturation: miss at 0000 -> 0000; with GAME_SECONDS=99 and TICK_DIV=20000, 10000 hits -> 9999, and a further hit -> 9999.
REQ-035 Ignore rules: hit in IDLE and in OVER -> score unchanged; start in RUN -> time and score unchanged; start in OVER -> RUN, time 10, score 0000.
REQ-036 Edge cases: hit on the final tick -> counted in the OVER score; rst_n asserted mid-RUN -> IDLE values, and a following start restarts the round from 10.
